// File: rtl/hyperbolic_cordic_iter_pkg.sv
// hyperbolic_cordic_iter_pkg: shared Q8.24 types, iteration schedule bounds and FSM encoding
package hyperbolic_cordic_iter_pkg;
    localparam int W       = 32;
    localparam int FRAC    = 24;
    localparam int I_FIRST = -3;
    localparam int I_LAST  = 13;
    localparam int REP_A   = 4;
    localparam int REP_B   = 13;
    typedef logic signed [W-1:0] q_t;
    typedef logic signed [4:0] idx_t;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/hyperbolic_cordic_iter_if.sv
// hyperbolic_cordic_iter_if: operand/result bundle between a requester and the CORDIC engine
interface hyperbolic_cordic_iter_if;
    import hyperbolic_cordic_iter_pkg::*;
    logic start;
    logic mode;
    logic busy;
    logic done;
    q_t   x_in;
    q_t   y_in;
    q_t   z_in;
    q_t   x_out;
    q_t   y_out;
    q_t   z_out;
    modport master (output start, mode, x_in, y_in, z_in, input busy, done, x_out, y_out, z_out);
    modport slave  (input start, mode, x_in, y_in, z_in, output busy, done, x_out, y_out, z_out);
endinterface

// File: rtl/hyperbolic_cordic_iter_atanh_lookup.sv
// hyperbolic_cordic_iter_atanh_lookup: Q8.24 micro-rotation angles; idx<=0 gives atanh(1-2^(idx-2)), idx>=1 gives atanh(2^-idx)
module hyperbolic_cordic_iter_atanh_lookup
    import hyperbolic_cordic_iter_pkg::*;
(
    input  idx_t idx,
    output q_t   atanh
);
    always_comb begin
        case (idx)
            -5'sd3:  atanh = 32'sd34755133;
            -5'sd2:  atanh = 32'sd28806373;
            -5'sd1:  atanh = 32'sd22716772;
            5'sd0:   atanh = 32'sd16323477;
            5'sd1:   atanh = 32'sd9215828;
            5'sd2:   atanh = 32'sd4285116;
            5'sd3:   atanh = 32'sd2108178;
            5'sd4:   atanh = 32'sd1049945;
            5'sd5:   atanh = 32'sd524459;
            5'sd6:   atanh = 32'sd262165;
            5'sd7:   atanh = 32'sd131075;
            5'sd8:   atanh = 32'sd65536;
            5'sd9:   atanh = 32'sd32768;
            5'sd10:  atanh = 32'sd16384;
            5'sd11:  atanh = 32'sd8192;
            5'sd12:  atanh = 32'sd4096;
            5'sd13:  atanh = 32'sd2048;
            default: atanh = '0;
        endcase
    end
endmodule

// File: rtl/hyperbolic_cordic_iter.sv
// hyperbolic_cordic_iter: iterative hyperbolic CORDIC, one micro-rotation per clock, indices -3..13 with 4 and 13 repeated
// Gain is left uncompensated; the downstream scaler removes it.
module hyperbolic_cordic_iter
    import hyperbolic_cordic_iter_pkg::*;
(
    input logic clk,
    input logic rst,
    hyperbolic_cordic_iter_if.slave bus
);
    logic [1:0] state;
    idx_t idx;
    logic rep, mode_r, neg, dpos, last, rep_hit;
    logic [4:0] sh;
    q_t x, y, z, a, tx, ty, x_nxt, y_nxt, z_nxt, xo, yo, zo;

    hyperbolic_cordic_iter_atanh_lookup u_atanh_lookup (.idx(idx), .atanh(a));

    // Negative indices use x - x*2^-(2-idx) so early steps cover the expanded range.
    always_comb begin
        neg     = idx <= idx_t'(0);
        sh      = neg ? 5'(2 - idx) : idx;
        tx      = neg ? x - (x >>> sh) : x >>> sh;
        ty      = neg ? y - (y >>> sh) : y >>> sh;
        dpos    = mode_r ? ~z[W-1] : y[W-1];
        x_nxt   = dpos ? x + ty : x - ty;
        y_nxt   = dpos ? y + tx : y - tx;
        z_nxt   = dpos ? z - a : z + a;
        last    = idx == idx_t'(I_LAST) && rep;
        rep_hit = (idx == idx_t'(REP_A) || idx == idx_t'(REP_B)) && !rep;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= idx_t'(I_FIRST);
            rep    <= 1'b0;
            mode_r <= 1'b0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            xo     <= '0;
            yo     <= '0;
            zo     <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    x      <= bus.x_in;
                    y      <= bus.y_in;
                    z      <= bus.z_in;
                    mode_r <= bus.mode;
                    state  <= S_LOAD;
                end
                S_LOAD: begin
                    idx   <= idx_t'(I_FIRST);
                    rep   <= 1'b0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    x <= x_nxt;
                    y <= y_nxt;
                    z <= z_nxt;
                    if (last) begin
                        xo    <= x_nxt;
                        yo    <= y_nxt;
                        zo    <= z_nxt;
                        idx   <= idx_t'(I_FIRST);
                        rep   <= 1'b0;
                        state <= S_DONE;
                    end else if (rep_hit) begin
                        rep <= 1'b1;
                    end else begin
                        rep <= 1'b0;
                        idx <= idx + idx_t'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = state == S_LOAD || state == S_ITER;
    assign bus.done  = state == S_DONE;
    assign bus.x_out = xo;
    assign bus.y_out = yo;
    assign bus.z_out = zo;
endmodule

// File: tb/tb_hyperbolic_cordic_iter.sv
// tb_hyperbolic_cordic_iter: scoreboard bench against a real-valued-table behavioural CORDIC model
module tb_hyperbolic_cordic_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hyperbolic_cordic_iter_if bus();
    hyperbolic_cordic_iter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string name;
        logic signed [31:0] x, y, z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t last;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint absd(input logic signed [31:0] p, input logic signed [31:0] q);
        longint d;
        d = longint'(p) - longint'(q);
        return d < 0 ? -d : d;
    endfunction

    function automatic logic signed [31:0] lut(input int k);
        real t;
        t = k <= 0 ? 1.0 - 2.0 ** (k - 2) : 2.0 ** (-k);
        return $rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) * 16777216.0 + 0.5);
    endfunction

    function automatic void model(input logic m, input logic signed [31:0] xi, input logic signed [31:0] yi,
                                  input logic signed [31:0] zi, output logic signed [31:0] xo,
                                  output logic signed [31:0] yo, output logic signed [31:0] zo);
        int sched [19];
        logic signed [31:0] x, y, z, tx, ty, a;
        logic d;
        sched = '{-3, -2, -1, 0, 1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};
        x = xi;
        y = yi;
        z = zi;
        foreach (sched[n]) begin
            tx = sched[n] <= 0 ? x - (x >>> (2 - sched[n])) : x >>> sched[n];
            ty = sched[n] <= 0 ? y - (y >>> (2 - sched[n])) : y >>> sched[n];
            a  = lut(sched[n]);
            d  = m ? (z >= 0) : (y < 0);
            x  = d ? x + ty : x - ty;
            y  = d ? y + tx : y - tx;
            z  = d ? z - a : z + a;
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_x"}, bus.x_out, mon_e.x);
                check({mon_e.name, "_y"}, bus.y_out, mon_e.y);
                check({mon_e.name, "_z_near_model"}, 32'(absd(bus.z_out, mon_e.z) <= 64), 1);
            end
        end
    end

    // Call at a negedge while idle; leaves start low at the following negedge.
    task automatic drive(input logic m, input logic signed [31:0] xi, input logic signed [31:0] yi,
                         input logic signed [31:0] zi, input string nm);
        exp_t e;
        model(m, xi, yi, zi, e.x, e.y, e.z);
        e.name = nm;
        last = e;
        sb.push_back(e);
        bus.mode  = m;
        bus.x_in  = xi;
        bus.y_in  = yi;
        bus.z_in  = zi;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(bus.done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        logic m;
        logic signed [31:0] xr, yr, zr;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        bus.z_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_x", bus.x_out, 0);
        check("rst_y", bus.y_out, 0);
        check("rst_z", bus.z_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Timing profile with a start pulse during busy that must be ignored.
        model(1'b0, 32'sh01000000, 32'sh00800000, 0, last.x, last.y, last.z);
        last.name = "vec_half";
        sb.push_back(last);
        bus.mode  = 1'b0;
        bus.x_in  = 32'sh01000000;
        bus.y_in  = 32'sh00800000;
        bus.z_in  = 0;
        bus.start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 5) begin
                bus.start = 1'b1;
                bus.x_in  = 32'sh00400000;
            end
            if (c == 6) bus.start = 1'b0;
            check($sformatf("busy_c%0d", c), 32'(bus.busy), 32'(c <= 20));
            check($sformatf("done_c%0d", c), 32'(bus.done), 32'(c == 21));
        end
        check("vec_half_z_atanh", 32'(absd(bus.z_out, 32'sh008C9F54) < 8192), 1);
        check("vec_half_y_small", 32'(absd(bus.y_out, 0) < 65536 / 256), 1);
        check("hold_x", bus.x_out, last.x);
        check("hold_z", bus.z_out, last.z);

        drive(1'b0, 32'sh01000000, 32'sh00E66666, 0, "vec_09");
        wait_done(n);
        check("vec_09_lat", n, 21);
        check("vec_09_z_atanh", 32'(absd(bus.z_out, $rtoi(0.5 * $ln(1.9 / 0.1) * 16777216.0)) < 8192), 1);
        check("vec_09_y_small", 32'(absd(bus.y_out, 0) < 256), 1);
        @(negedge clk);

        drive(1'b1, 32'sh01000000, 0, 32'sh008C9F54, "rot_half");
        wait_done(n);
        check("rot_half_z_small", 32'(absd(bus.z_out, 0) < 4096), 1);
        @(negedge clk);

        // Abort at iteration 10.
        drive(1'b1, 32'sh00C00000, 32'sh00200000, 32'sh00400000, "rot_abort");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_x", bus.x_out, 0);
        check("abort_y", bus.y_out, 0);
        check("abort_z", bus.z_out, 0);
        n = done_cnt;
        repeat (25) @(negedge clk);
        check("abort_no_done", done_cnt, n);
        drive(1'b0, 32'sh01000000, 32'sh00800000, 0, "after_abort");
        wait_done(n);
        check("after_abort_lat", n, 21);

        // Back-to-back: start raised during done is ignored, held into the next cycle it is accepted.
        bus.mode  = 1'b0;
        bus.x_in  = 32'sh01000000;
        bus.y_in  = 32'shFFC00000;
        bus.z_in  = 0;
        bus.start = 1'b1;
        @(negedge clk);
        check("done_start_ignored", 32'(bus.busy), 0);
        drive(1'b0, 32'sh01000000, 32'shFFC00000, 0, "b2b");
        wait_done(n);
        check("b2b_lat", n, 21);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            m  = i[0];
            xr = 32'($urandom_range(8388608, 25165824));
            yr = m ? 32'(int'($urandom_range(0, 33554432)) - 16777216)
                   : 32'(int'($urandom_range(0, 32'(xr) * 3 / 2)) - int'(xr) * 3 / 4);
            zr = m ? 32'(int'($urandom_range(0, 50331648)) - 25165824) : 0;
            drive(m, xr, yr, zr, $sformatf("rand%0d", i));
            wait_done(n);
            check($sformatf("rand%0d_lat", i), n, 21);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
